rng_roll_sequencer: RTL

Controller that sequences the 16-bit LFSR random-number datapath for the "dice roll" display. On a start pulse it seeds the LFSR from a free-running counter. It then advances the LFSR on a decelerating schedule (slot-machine effect) and latches each new 4-bit result for display. It freezes on the final value, or earlier on a stop pulse. It sits between the debounced push-button inputs and the LFSR/7-segment path.

---
 rtl/rng_roll_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rng_roll_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rng_roll_sequencer
// Purpose  : Sequences the 16-bit LFSR for the dice-roll display. A start
//            pulse seeds the LFSR from a free-running counter. The LFSR is
//            then advanced on a decelerating schedule, where each stage
//            doubles the step period. Each new nibble is latched for display.
//            The sequence freezes on the final value, or earlier on a stop
//            pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk        in   1   clock
//   i_rst_n      in   1   asynchronous active-low reset
//   i_start      in   1   single-cycle start pulse (honoured only in IDLE)
//   i_stop       in   1   single-cycle early-stop pulse (honoured only in RUN)
//   i_rand       in   4   LFSR low nibble
//   o_seed       out  16  seed value, valid while o_seed_load = 1
//   o_seed_load  out  1   one-cycle LFSR load strobe
//   o_step       out  1   one-cycle LFSR advance strobe
//   o_value      out  4   latched displayed result
//   o_busy       out  1   high in SEED and RUN
//   o_done       out  1   one-cycle completion pulse
// ============================================================================
module rng_roll_sequencer #(
  parameter int BASE_PERIOD     = 2_500_000,
  parameter int NUM_STAGES      = 6,
  parameter int STEPS_PER_STAGE = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [3:0]  i_rand,
  output logic [15:0] o_seed,
  output logic        o_seed_load,
  output logic        o_step,
  output logic [3:0]  o_value,
  output logic        o_busy,
  output logic        o_done
);

  // stage must be able to hold NUM_STAGES, which is the "all steps issued" marker
  localparam int STAGE_W = $clog2(NUM_STAGES + 1);
  localparam int STEP_W  = (STEPS_PER_STAGE > 1) ? $clog2(STEPS_PER_STAGE) : 1;

  localparam logic [31:0]        BASE_P    = 32'(BASE_PERIOD);
  localparam logic [STAGE_W-1:0] STAGE_END = STAGE_W'(NUM_STAGES);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEPS_PER_STAGE - 1);
  // An all-zero LFSR state never leaves zero, so a zero seed is replaced
  localparam logic [15:0]        ZERO_SUB  = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [15:0]        seed_cnt;
  logic [31:0]        timer;
  logic [STAGE_W-1:0] stage;
  logic [STEP_W-1:0]  step_cnt;
  logic               cap_pending;   // an o_step happened last cycle
  logic [31:0]        period_last;
  logic               exhausted;

  assign period_last = (BASE_P << stage) - 32'd1;
  assign exhausted   = (stage == STAGE_END);
  assign o_step      = (state == RUN) && (timer == period_last) && !exhausted && !i_stop;

  // Free-running seed source; it runs in every state so that the seed
  // depends on how long the user waited before pressing start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seed_cnt <= 16'd0;
    end else begin
      seed_cnt <= seed_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      timer       <= 32'd0;
      stage       <= '0;
      step_cnt    <= '0;
      cap_pending <= 1'b0;
      o_seed      <= 16'd0;
      o_value     <= 4'd0;
      o_seed_load <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            o_seed      <= (seed_cnt == 16'd0) ? ZERO_SUB : seed_cnt;
            o_seed_load <= 1'b1;
            o_busy      <= 1'b1;
            state       <= SEED;
          end
        end

        SEED: begin
          o_seed_load <= 1'b0;
          timer       <= 32'd0;
          stage       <= '0;
          step_cnt    <= '0;
          cap_pending <= 1'b0;
          state       <= RUN;
        end

        RUN: begin
          // The LFSR output reflects an advance one cycle after the strobe.
          cap_pending <= o_step;
          if (cap_pending) begin
            o_value <= i_rand;
          end

          if (o_step) begin
            timer <= 32'd0;
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              stage    <= stage + 1'b1;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 32'd1;
          end

          // Normal end is the cycle carrying the final capture. A stop
          // ends the run at once, and a pending capture still lands above.
          if (i_stop || (exhausted && cap_pending)) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
